// File: rtl/alu_pkg.sv
// Shared op and FSM state encodings for the round-robin ALU arbiter.
package alu_pkg;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_INC  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_core.sv
// Combinational 4-op ALU: pass-a, add with carry-out, wrapping subtract, increment.
// Zero latency; no flow control of its own.
module alu_core
  import alu_pkg::*;
#(
  parameter int DATA_W = 5,
  parameter int RES_W  = DATA_W + 1
) (
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [RES_W-1:0]  result
);

  logic [DATA_W-1:0] diff;

  always_comb begin
    // Subtract wraps at DATA_W bits so the top result bit stays clear.
    diff   = a - b;
    result = '0;
    case (op)
      OP_PASS: result = RES_W'(a);
      OP_ADD:  result = RES_W'(a) + RES_W'(b);
      OP_SUB:  result = RES_W'(diff);
      default: result = RES_W'(a) + RES_W'(1);
    endcase
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for one ALU; accept -> rsp_valid two edges later.
// One op in flight; requesters see ready only in IDLE, response held until rsp_ready.
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 5,
  parameter int RES_W  = DATA_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [RES_W-1:0]  rsp_data,
  output logic              busy
);

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [1:0]        cap_op_q, cap_op_d;
  logic [DATA_W-1:0] cap_a_q, cap_a_d;
  logic [DATA_W-1:0] cap_b_q, cap_b_d;
  logic              cap_id_q, cap_id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [RES_W-1:0]  rsp_data_q, rsp_data_d;

  logic              gnt_vld;
  logic              gnt_id;
  logic              accept;
  logic [RES_W-1:0]  alu_res;

  alu_core #(
    .DATA_W (DATA_W),
    .RES_W  (RES_W)
  ) u_alu_core (
    .op     (cap_op_q),
    .a      (cap_a_q),
    .b      (cap_b_q),
    .result (alu_res)
  );

  // Under contention the requester that did not win last time gets the slot.
  always_comb begin
    gnt_vld = req0_valid | req1_valid;
    gnt_id  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
  end

  assign req0_ready = (state_q == ST_IDLE) && gnt_vld && !gnt_id;
  assign req1_ready = (state_q == ST_IDLE) && gnt_vld && gnt_id;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cap_op_d     = cap_op_q;
    cap_a_d      = cap_a_q;
    cap_b_d      = cap_b_q;
    cap_id_d     = cap_id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cap_op_d     = gnt_id ? req1_op : req0_op;
          cap_a_d      = gnt_id ? req1_a  : req0_a;
          cap_b_d      = gnt_id ? req1_b  : req0_b;
          cap_id_d     = gnt_id;
          last_grant_d = gnt_id;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_data_d  = alu_res;
        rsp_id_d    = cap_id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      cap_op_q     <= '0;
      cap_a_q      <= '0;
      cap_b_q      <= '0;
      cap_id_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cap_op_q     <= cap_op_d;
      cap_a_q      <= cap_a_d;
      cap_b_q      <= cap_b_d;
      cap_id_q     <= cap_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Randomized and directed bench for alu_rr_arbiter against a transaction-level model.
module tb_alu_rr_arbiter;

  localparam int DATA_W = 5;
  localparam int RES_W  = DATA_W + 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0_valid, req0_ready;
  logic [1:0]        req0_op;
  logic [DATA_W-1:0] req0_a, req0_b;
  logic              req1_valid, req1_ready;
  logic [1:0]        req1_op;
  logic [DATA_W-1:0] req1_a, req1_b;
  logic              rsp_valid, rsp_ready, rsp_id, busy;
  logic [RES_W-1:0]  rsp_data;

  alu_rr_arbiter #(.DATA_W(DATA_W), .RES_W(RES_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Transaction-level model: is an op outstanding, how long since accept, what it should return.
  bit m_busy = 1'b0;
  int m_age  = 0;
  int m_last = 1;
  int m_exp_id, m_exp_data;
  int acc_cnt = 0;
  int rsp_ids[$];
  int rsp_datas[$];

  function automatic int ref_result(input int op, input int a, input int b);
    int m;
    m = 1 << DATA_W;
    case (op)
      0:       return a;
      1:       return a + b;
      2:       return (a - b + m) % m;
      default: return a + 1;
    endcase
  endfunction

  task automatic step();
    int win, op_w, a_w, b_w, cap_data, o_id, o_data;
    bit exp_vld, hs;
    @(negedge clk);
    win = -1;
    if (req0_valid && !req1_valid) win = 0;
    else if (req1_valid && !req0_valid) win = 1;
    else if (req0_valid && req1_valid) win = (m_last == 0) ? 1 : 0;
    exp_vld = m_busy && (m_age >= 1);
    chk("req0_ready", 32'(req0_ready), 32'(!m_busy && win == 0));
    chk("req1_ready", 32'(req1_ready), 32'(!m_busy && win == 1));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
    if (exp_vld) begin
      chk("rsp_id", 32'(rsp_id), 32'(m_exp_id));
      chk("rsp_data", 32'(rsp_data), 32'(m_exp_data));
    end
    op_w = (win == 1) ? int'(req1_op) : int'(req0_op);
    a_w  = (win == 1) ? int'(req1_a)  : int'(req0_a);
    b_w  = (win == 1) ? int'(req1_b)  : int'(req0_b);
    cap_data = ref_result(op_w, a_w, b_w);
    hs     = exp_vld && rsp_ready;
    o_id   = int'(rsp_id);
    o_data = int'(rsp_data);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_age  = 0;
      m_last = 1;
    end else if (!m_busy && win >= 0) begin
      m_busy     = 1'b1;
      m_age      = 0;
      m_last     = win;
      m_exp_id   = win;
      m_exp_data = cap_data;
      acc_cnt++;
    end else if (m_busy) begin
      if (hs) begin
        m_busy = 1'b0;
        rsp_ids.push_back(o_id);
        rsp_datas.push_back(o_data);
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic drive(input int id, input bit v, input int op, input int a, input int b);
    if (id == 0) begin
      req0_valid = v; req0_op = 2'(op); req0_a = DATA_W'(a); req0_b = DATA_W'(b);
    end else begin
      req1_valid = v; req1_op = 2'(op); req1_a = DATA_W'(a); req1_b = DATA_W'(b);
    end
  endtask

  // Issue one op from a lone requester; a_after replaces operand a right after acceptance.
  task automatic run_one(input int id, input int op, input int a, input int b, input int a_after,
                         output int got_id, output int got_data);
    int start;
    start = acc_cnt;
    drive(id, 1'b1, op, a, b);
    for (int k = 0; k < 10 && acc_cnt == start; k++) step();
    if (acc_cnt == start) chk("accept_timeout", 0, 1);
    drive(id, 1'b0, op, a_after, b);
    for (int k = 0; k < 10 && rsp_ids.size() == 0; k++) step();
    got_id = -1; got_data = -1;
    if (rsp_ids.size() == 0) chk("response_timeout", 0, 1);
    else begin
      got_id   = rsp_ids.pop_front();
      got_data = rsp_datas.pop_front();
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    for (int k = 0; k < cycles; k++) step();
    rst_n = 1'b1;
  endtask

  initial begin
    int gid, gdat, start, nrsp;
    int exp_ids[3];
    int exp_dat[3];
    int seq_res[4];
    rst_n = 1'b0; rsp_ready = 1'b1;
    drive(0, 1'b0, 0, 0, 0);
    drive(1, 1'b0, 0, 0, 0);
    #1;
    do_reset(3);
    chk("reset_rsp_data", 32'(rsp_data), 0);
    chk("reset_rsp_id", 32'(rsp_id), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_busy", 32'(busy), 0);

    // Requester 0 alone, all four ops on a=5 b=2.
    seq_res = '{5, 7, 3, 6};
    for (int op = 0; op < 4; op++) begin
      run_one(0, op, 5, 2, 5, gid, gdat);
      chk("seq_data", 32'(gdat), 32'(seq_res[op]));
      chk("seq_id", 32'(gid), 0);
    end

    // Width boundaries.
    run_one(0, 1, 31, 31, 31, gid, gdat); chk("add_carry", 32'(gdat), 62);
    run_one(1, 3, 31, 0, 31, gid, gdat);  chk("inc_wrap", 32'(gdat), 32);
    chk("inc_id", 32'(gid), 1);
    run_one(0, 2, 2, 5, 2, gid, gdat);    chk("sub_underflow", 32'(gdat), 29);

    // Contention from reset: both hold valid, grant alternates starting at requester 0.
    do_reset(1);
    drive(0, 1'b1, 1, 3, 4);
    drive(1, 1'b1, 3, 9, 0);
    for (int k = 0; k < 30 && rsp_ids.size() < 3; k++) step();
    drive(0, 1'b0, 1, 3, 4);
    drive(1, 1'b0, 3, 9, 0);
    exp_ids = '{0, 1, 0};
    exp_dat = '{7, 10, 7};
    if (rsp_ids.size() < 3) chk("contention_timeout", 32'(rsp_ids.size()), 3);
    for (int i = 0; i < 3 && rsp_ids.size() > 0; i++) begin
      chk("cont_id", 32'(rsp_ids.pop_front()), 32'(exp_ids[i]));
      chk("cont_data", 32'(rsp_datas.pop_front()), 32'(exp_dat[i]));
    end
    for (int k = 0; k < 4; k++) step();
    rsp_ids.delete(); rsp_datas.delete();

    // Backpressure: response held 4 cycles while requester 1 waits.
    rsp_ready = 1'b0;
    start = acc_cnt;
    drive(0, 1'b1, 1, 10, 6);
    for (int k = 0; k < 10 && acc_cnt == start; k++) step();
    drive(0, 1'b0, 0, 0, 0);
    drive(1, 1'b1, 0, 17, 0);
    step();
    chk("bp_valid", 32'(rsp_valid), 1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("bp_hold_data", 32'(rsp_data), 16);
      chk("bp_hold_id", 32'(rsp_id), 0);
      chk("bp_no_ready", 32'(req1_ready), 0);
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_next_ready", 32'(req1_ready), 1);
    step();
    drive(1, 1'b0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step();
    rsp_ids.delete(); rsp_datas.delete();

    // Operand a changes after acceptance.
    run_one(0, 1, 5, 1, 20, gid, gdat);
    chk("late_operand", 32'(gdat), 6);

    // Reset while the op is in EXEC discards it.
    do_reset(1);
    start = acc_cnt;
    drive(1, 1'b1, 1, 3, 4);
    for (int k = 0; k < 10 && acc_cnt == start; k++) step();
    drive(1, 1'b0, 0, 0, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_valid", 32'(rsp_valid), 0);
    nrsp = rsp_ids.size();
    for (int k = 0; k < 5; k++) step();
    chk("rst_mid_no_rsp", 32'(rsp_ids.size()), 32'(nrsp));
    drive(0, 1'b1, 0, 1, 0);
    drive(1, 1'b1, 0, 2, 0);
    #1;
    chk("rst_first_grant0", 32'(req0_ready), 1);
    chk("rst_first_grant1", 32'(req1_ready), 0);
    step();
    drive(0, 1'b0, 0, 0, 0);
    drive(1, 1'b0, 0, 0, 0);
    for (int k = 0; k < 4; k++) step();

    // Random traffic, including occasional resets.
    for (int c = 0; c < 2000; c++) begin
      rst_n      = ($urandom_range(0, 99) != 0);
      rsp_ready  = ($urandom_range(0, 9) < 7);
      drive(0, $urandom_range(0, 9) < 6, int'($urandom_range(0, 3)),
            int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      drive(1, $urandom_range(0, 9) < 6, int'($urandom_range(0, 3)),
            int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      step();
    end
    rst_n = 1'b1; rsp_ready = 1'b1;
    drive(0, 1'b0, 0, 0, 0);
    drive(1, 1'b0, 0, 0, 0);
    for (int k = 0; k < 5; k++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
